// File: rtl/id_pipe_stage.sv
// Instruction-decode stage: register file read, load-use interlock and the ID/EX
// pipeline register. Optional write-first read bypass: define ID_PIPE_WB_BYPASS_EN.
module id_pipe_stage #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 24,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_mem_read,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [AW-1:0]     out_rs1_adr,
  output logic [AW-1:0]     out_rs2_adr,
  output logic [AW-1:0]     out_rd_adr,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_mem_read,
  output logic              out_reg_write,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_adr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [15:0]       stall_cnt
);

  logic [AW-1:0]     dec_rs1;
  logic [AW-1:0]     dec_rs2;
  logic [AW-1:0]     dec_rd;
  logic              unused_inst_bits;

  logic [XLEN-1:0]   rf_q [NREGS];
  logic [XLEN-1:0]   rf_d [NREGS];
  logic              wb_wr_en;
  logic [XLEN-1:0]   rs1_rd_data;
  logic [XLEN-1:0]   rs2_rd_data;

  logic              advance;
  logic              hazard;
  logic              take;

  logic              out_valid_q,     out_valid_d;
  logic [XLEN-1:0]   out_pc_q,        out_pc_d;
  logic [XLEN-1:0]   out_rs1_data_q,  out_rs1_data_d;
  logic [XLEN-1:0]   out_rs2_data_q,  out_rs2_data_d;
  logic [AW-1:0]     out_rs1_adr_q,   out_rs1_adr_d;
  logic [AW-1:0]     out_rs2_adr_q,   out_rs2_adr_d;
  logic [AW-1:0]     out_rd_adr_q,    out_rd_adr_d;
  logic [2:0]        out_funct3_q,    out_funct3_d;
  logic [6:0]        out_funct7_q,    out_funct7_d;
  logic [CTRL_W-1:0] out_ctrl_q,      out_ctrl_d;
  logic              out_mem_read_q,  out_mem_read_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic [15:0]       stall_cnt_q,     stall_cnt_d;

  assign dec_rs1 = in_inst[15 +: AW];
  assign dec_rs2 = in_inst[20 +: AW];
  assign dec_rd  = in_inst[7 +: AW];
  // Opcode and upper address bits are decoded upstream into in_ctrl.
  assign unused_inst_bits = ^in_inst;

  // Register file; entry 0 is never written so it stays at its reset value of 0.
  assign wb_wr_en = wb_we & (wb_adr != '0);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wb_wr_en) begin
      rf_d[wb_adr] = wb_data;
    end
  end

  always_comb begin
    rs1_rd_data = rf_q[dec_rs1];
    rs2_rd_data = rf_q[dec_rs2];
`ifdef ID_PIPE_WB_BYPASS_EN
    if (wb_wr_en && (wb_adr == dec_rs1)) begin
      rs1_rd_data = wb_data;
    end
    if (wb_wr_en && (wb_adr == dec_rs2)) begin
      rs2_rd_data = wb_data;
    end
`endif
  end

  // Load-use interlock: a load sitting in ID/EX cannot yet forward to its consumer.
  assign advance  = ~out_valid_q | out_ready;
  assign hazard   = out_valid_q & out_mem_read_q & (out_rd_adr_q != '0) & in_valid &
                    ((dec_rs1 == out_rd_adr_q) | (dec_rs2 == out_rd_adr_q));
  assign in_ready = advance & ~hazard;
  assign take     = advance & in_valid & ~hazard;

  always_comb begin
    out_valid_d     = out_valid_q;
    out_pc_d        = out_pc_q;
    out_rs1_data_d  = out_rs1_data_q;
    out_rs2_data_d  = out_rs2_data_q;
    out_rs1_adr_d   = out_rs1_adr_q;
    out_rs2_adr_d   = out_rs2_adr_q;
    out_rd_adr_d    = out_rd_adr_q;
    out_funct3_d    = out_funct3_q;
    out_funct7_d    = out_funct7_q;
    out_ctrl_d      = out_ctrl_q;
    out_mem_read_d  = out_mem_read_q;
    out_reg_write_d = out_reg_write_q;

    if (flush || (advance && !take)) begin
      // Kill or bubble: only the control side needs clearing.
      out_valid_d     = 1'b0;
      out_ctrl_d      = '0;
      out_mem_read_d  = 1'b0;
      out_reg_write_d = 1'b0;
    end else if (take) begin
      out_valid_d     = 1'b1;
      out_pc_d        = in_pc;
      out_rs1_data_d  = rs1_rd_data;
      out_rs2_data_d  = rs2_rd_data;
      out_rs1_adr_d   = dec_rs1;
      out_rs2_adr_d   = dec_rs2;
      out_rd_adr_d    = dec_rd;
      out_funct3_d    = in_inst[14:12];
      out_funct7_d    = in_inst[31:25];
      out_ctrl_d      = in_ctrl;
      out_mem_read_d  = in_mem_read;
      out_reg_write_d = in_reg_write;
    end else begin
      // Holding: keep operands current with writebacks landing while EX is stalled.
      if (wb_wr_en && (wb_adr == out_rs1_adr_q)) begin
        out_rs1_data_d = wb_data;
      end
      if (wb_wr_en && (wb_adr == out_rs2_adr_q)) begin
        out_rs2_data_d = wb_data;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // ID/EX register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_pc_q        <= '0;
      out_rs1_data_q  <= '0;
      out_rs2_data_q  <= '0;
      out_rs1_adr_q   <= '0;
      out_rs2_adr_q   <= '0;
      out_rd_adr_q    <= '0;
      out_funct3_q    <= '0;
      out_funct7_q    <= '0;
      out_ctrl_q      <= '0;
      out_mem_read_q  <= 1'b0;
      out_reg_write_q <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_pc_q        <= out_pc_d;
      out_rs1_data_q  <= out_rs1_data_d;
      out_rs2_data_q  <= out_rs2_data_d;
      out_rs1_adr_q   <= out_rs1_adr_d;
      out_rs2_adr_q   <= out_rs2_adr_d;
      out_rd_adr_q    <= out_rd_adr_d;
      out_funct3_q    <= out_funct3_d;
      out_funct7_q    <= out_funct7_d;
      out_ctrl_q      <= out_ctrl_d;
      out_mem_read_q  <= out_mem_read_d;
      out_reg_write_q <= out_reg_write_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_rs1_data  = out_rs1_data_q;
  assign out_rs2_data  = out_rs2_data_q;
  assign out_rs1_adr   = out_rs1_adr_q;
  assign out_rs2_adr   = out_rs2_adr_q;
  assign out_rd_adr    = out_rd_adr_q;
  assign out_funct3    = out_funct3_q;
  assign out_funct7    = out_funct7_q;
  assign out_ctrl      = out_ctrl_q;
  assign out_mem_read  = out_mem_read_q;
  assign out_reg_write = out_reg_write_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level model of the ID stage.
module tb_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_inst;
  logic [23:0] in_ctrl;
  logic        in_mem_read, in_reg_write, flush, out_ready;
  logic        out_valid;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data;
  logic [4:0]  out_rs1_adr, out_rs2_adr, out_rd_adr;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [23:0] out_ctrl;
  logic        out_mem_read, out_reg_write;
  logic        wb_we;
  logic [4:0]  wb_adr;
  logic [31:0] wb_data;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_pipe_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_ctrl(in_ctrl), .in_mem_read(in_mem_read), .in_reg_write(in_reg_write),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rs1_adr(out_rs1_adr), .out_rs2_adr(out_rs2_adr), .out_rd_adr(out_rd_adr),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_ctrl(out_ctrl),
    .out_mem_read(out_mem_read), .out_reg_write(out_reg_write),
    .wb_we(wb_we), .wb_adr(wb_adr), .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, 7'h03};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_pc = '0; in_inst = '0; in_ctrl = '0;
    in_mem_read = 1'b0; in_reg_write = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_adr = '0; wb_data = '0;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic mr);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_mem_read = mr;
    in_reg_write = 1'b1; in_ctrl = pc[23:0] ^ 24'h5A5A5A;
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d;
    logic [4:0]  rs1a, rs2a, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [23:0] ctrl;
    logic        mr, rw;
  } idex_t;

  idex_t       m_out, m_nxt;
  logic [31:0] m_rf [32];
  int          m_stall, m_nxt_stall;
  logic        m_exp_ready;

  task automatic model_reset();
    m_out = '{default: '0};
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_stall = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ID_PIPE_WB_BYPASS_EN
    if (wb_we && wb_adr == r) return wb_data;
`endif
    return m_rf[r];
  endfunction

  task automatic model_eval();
    logic [4:0] rs1, rs2;
    logic load_use, ex_free, wb_live;
    rs1 = in_inst[19:15];
    rs2 = in_inst[24:20];
    load_use = m_out.valid && m_out.mr && (m_out.rd != 0) && in_valid &&
               (rs1 == m_out.rd || rs2 == m_out.rd);
    ex_free = !m_out.valid || out_ready;
    m_exp_ready = ex_free && !load_use;
    wb_live = wb_we && (wb_adr != 0);
    m_nxt = m_out;
    if (flush || (ex_free && !(in_valid && m_exp_ready))) begin
      m_nxt.valid = 0; m_nxt.ctrl = '0; m_nxt.mr = 0; m_nxt.rw = 0;
    end else if (ex_free) begin
      m_nxt = '{1'b1, in_pc, m_read(rs1), m_read(rs2), rs1, rs2, in_inst[11:7],
                in_inst[14:12], in_inst[31:25], in_ctrl, in_mem_read, in_reg_write};
    end else begin
      if (wb_live && wb_adr == m_out.rs1a) m_nxt.rs1d = wb_data;
      if (wb_live && wb_adr == m_out.rs2a) m_nxt.rs2d = wb_data;
    end
    m_nxt_stall = m_stall;
    if (in_valid && !m_exp_ready && !flush) m_nxt_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
    if (wb_live) m_rf[wb_adr] = wb_data;
  endtask

  task automatic model_compare();
    chk("rnd_out_valid", 64'(out_valid), 64'(m_out.valid));
    chk("rnd_out_ctrl", 64'(out_ctrl), 64'(m_out.ctrl));
    chk("rnd_out_mem_read", 64'(out_mem_read), 64'(m_out.mr));
    chk("rnd_out_reg_write", 64'(out_reg_write), 64'(m_out.rw));
    chk("rnd_stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (m_out.valid) begin
      chk("rnd_out_pc", 64'(out_pc), 64'(m_out.pc));
      chk("rnd_rs1_data", 64'(out_rs1_data), 64'(m_out.rs1d));
      chk("rnd_rs2_data", 64'(out_rs2_data), 64'(m_out.rs2d));
      chk("rnd_rs1_adr", 64'(out_rs1_adr), 64'(m_out.rs1a));
      chk("rnd_rs2_adr", 64'(out_rs2_adr), 64'(m_out.rs2a));
      chk("rnd_rd_adr", 64'(out_rd_adr), 64'(m_out.rd));
      chk("rnd_funct3", 64'(out_funct3), 64'(m_out.f3));
      chk("rnd_funct7", 64'(out_funct7), 64'(m_out.f7));
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mem_read;
    logic        out_ready;
    logic        wb_we;
    logic [4:0]  wb_adr;
    logic [31:0] wb_data;
    logic        exp_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vt [9];

  logic [31:0] exp_bypass;
  int          exp_stall;

  initial begin
    vt[0] = '{1'b0, 32'h0,            32'h000, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,  16'd0};
    vt[1] = '{1'b1, r_add(5'd1, 5'd5, 5'd0), 32'h100, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1234, 32'h0,  16'd0};
    vt[2] = '{1'b1, i_lw(5'd3, 5'd5), 32'h104, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h1234, 32'h0,  16'd0};
    vt[3] = '{1'b1, r_add(5'd4, 5'd3, 5'd3), 32'h108, 1'b0, 1'b1, 1'b1, 5'd3, 32'h77, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,  16'd1};
    vt[4] = '{1'b1, r_add(5'd4, 5'd3, 5'd3), 32'h108, 1'b0, 1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b1, 1'b1, 32'h77, 32'h77, 16'd1};
    vt[5] = '{1'b1, r_add(5'd1, 5'd0, 5'd0), 32'h10C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0,   16'd1};
    vt[6] = '{1'b1, i_lw(5'd0, 5'd5), 32'h110, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h1234, 32'h0,  16'd1};
    vt[7] = '{1'b1, r_add(5'd2, 5'd0, 5'd0), 32'h114, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0,   16'd1};
    vt[8] = '{1'b0, 32'h0,            32'h000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0,  16'd1};

    // Reset acts before any clock edge.
    idle_inputs();
    rst_n = 1'b0;
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      if (vt[i].in_valid) issue(vt[i].inst, vt[i].pc, vt[i].mem_read);
      out_ready = vt[i].out_ready;
      wb_we = vt[i].wb_we; wb_adr = vt[i].wb_adr; wb_data = vt[i].wb_data;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(vt[i].exp_ready));
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
      chk($sformatf("tbl%0d_stall_cnt", i), 64'(stall_cnt), 64'(vt[i].exp_stall));
      if (vt[i].chk_data) begin
        chk($sformatf("tbl%0d_rs1_data", i), 64'(out_rs1_data), 64'(vt[i].exp_rs1));
        chk($sformatf("tbl%0d_rs2_data", i), 64'(out_rs2_data), 64'(vt[i].exp_rs2));
        chk($sformatf("tbl%0d_out_pc", i), 64'(out_pc), 64'(vt[i].pc));
      end
    end

    // Same-cycle writeback and read of x7.
    do_reset();
    issue(i_lw(5'd8, 5'd7), 32'h180, 1'b1);
    wb_we = 1'b1; wb_adr = 5'd7; wb_data = 32'hAA;
    #1;
    chk("wbsame_in_ready", 64'(in_ready), 64'd1);
    tick();
`ifdef ID_PIPE_WB_BYPASS_EN
    exp_bypass = 32'hAA;
`else
    exp_bypass = 32'h0;
`endif
    chk("wbsame_rs1_data", 64'(out_rs1_data), 64'(exp_bypass));
    idle_inputs();
    issue(r_add(5'd9, 5'd7, 5'd7), 32'h184, 1'b0);
    tick();
    chk("wbafter_rs1_data", 64'(out_rs1_data), 64'h0AA);
    chk("wbafter_rd_adr", 64'(out_rd_adr), 64'd9);

    // Hold with writeback refresh of both operands.
    issue(r_add(5'd10, 5'd1, 5'd9), 32'h200, 1'b0);
    tick();
    chk("hold_load_rs2_adr", 64'(out_rs2_adr), 64'd9);
    issue(r_add(5'd11, 5'd2, 5'd2), 32'h204, 1'b0);
    out_ready = 1'b0;
    wb_we = 1'b1; wb_adr = 5'd1; wb_data = 32'h66;
    #1;
    chk("hold_in_ready", 64'(in_ready), 64'd0);
    tick();
    wb_we = 1'b1; wb_adr = 5'd9; wb_data = 32'h55;
    tick();
    wb_we = 1'b0;
    tick();
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    chk("hold_out_pc", 64'(out_pc), 64'h200);
    chk("hold_rs1_data", 64'(out_rs1_data), 64'h66);
    chk("hold_rs2_data", 64'(out_rs2_data), 64'h55);
    chk("hold_stall_cnt", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("release_out_pc", 64'(out_pc), 64'h204);
    chk("release_stall_cnt", 64'(stall_cnt), 64'd3);

    // Flush alongside an accepted instruction.
    issue(r_add(5'd12, 5'd1, 5'd1), 32'h208, 1'b1);
    in_ctrl = 24'hFFFFFF;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_out_mem_read", 64'(out_mem_read), 64'd0);
    chk("flush_out_reg_write", 64'(out_reg_write), 64'd0);
    idle_inputs();
    tick();
    chk("flush_discarded", 64'(out_valid), 64'd0);

    // Flush during a hold: entry killed and no stall counted.
    issue(r_add(5'd13, 5'd2, 5'd2), 32'h20C, 1'b0);
    tick();
    chk("pre_flush_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0; flush = 1'b1;
    tick();
    chk("flush_hold_valid", 64'(out_valid), 64'd0);
    chk("flush_hold_stall", 64'(stall_cnt), 64'd3);
    flush = 1'b0;

    // Asynchronous reset pulse in the middle of a hold.
    out_ready = 1'b1;
    issue(r_add(5'd14, 5'd9, 5'd1), 32'h210, 1'b1);
    tick();
    out_ready = 1'b0;
    tick();
    chk("prerst_stall_cnt", 64'(stall_cnt), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    chk("arst_rs1_data", 64'(out_rs1_data), 64'd0);
    chk("arst_rs2_data", 64'(out_rs2_data), 64'd0);
    chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("arst_mem_read", 64'(out_mem_read), 64'd0);
    chk("arst_rd_adr", 64'(out_rd_adr), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("postrst_out_valid", 64'(out_valid), 64'd1);
    chk("postrst_rf_cleared_rs1", 64'(out_rs1_data), 64'd0);
    chk("postrst_rf_cleared_rs2", 64'(out_rs2_data), 64'd0);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 9) == 0);
      in_mem_read  = ($urandom_range(0, 9) < 4);
      in_reg_write = ($urandom_range(0, 1) == 1);
      in_ctrl      = 24'($urandom());
      in_pc        = $urandom();
      in_inst      = {7'($urandom()), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      3'($urandom()), 5'($urandom_range(0, 7)), 7'($urandom())};
      wb_we        = ($urandom_range(0, 1) == 1);
      wb_adr       = 5'($urandom_range(0, 7));
      wb_data      = $urandom();
      #1;
      model_eval();
      chk("rnd_in_ready", 64'(in_ready), 64'(m_exp_ready));
      tick();
      m_out = m_nxt;
      m_stall = m_nxt_stall;
      model_compare();
    end

    // Stall counter saturation.
    do_reset();
    issue(r_add(5'd1, 5'd2, 5'd3), 32'h300, 1'b0);
    tick();
    out_ready = 1'b0;
    exp_stall = 0;
    for (int c = 1; c <= 70000; c++) begin
      @(posedge clk);
      #1;
      exp_stall = (exp_stall < 65535) ? exp_stall + 1 : 65535;
      if (c == 65534 || c == 65535 || c == 70000)
        chk($sformatf("sat_stall_cnt_%0d", c), 64'(stall_cnt), 64'(exp_stall));
    end
    chk("sat_out_pc_held", 64'(out_pc), 64'h300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
